// File: rtl/btb_predictor.sv
// -----------------------------------------------------------------------------
// btb_predictor
//
// Branch target buffer with a per-entry 2-bit direction counter for the
// pipelined TSC CPU. The table is direct-mapped and tagged. The IF stage gets a
// zero-latency next-PC prediction. The ID stage writes branch resolutions back
// into the table on the rising clock edge.
//
// Ports
//   clk             clock; every state update happens on posedge
//   reset_n         asynchronous active-low reset
//   IF_pc           PC currently being fetched
//   predicted_pc    next PC for the IF stage
//   btb_hit         valid entry whose tag matches IF_pc
//   pred_taken      prediction redirects fetch to the stored target
//   resolve_valid   ID instruction resolves this cycle (one pulse per instruction)
//   is_J_JR_Branch  ID kind: 0 none, 1 JMP/JAL, 2 JPR/JRL, 3 conditional branch
//   ID_pc           PC of the resolving instruction
//   BtbWrite        IF-stage guess for the ID instruction was wrong
//   target_address  resolved target of the ID instruction
//   branch_taken    conditional branch outcome (used only for kind 3)
// -----------------------------------------------------------------------------
module btb_predictor #(
    parameter int WORD_SIZE  = 16,
    parameter int INDEX_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic [WORD_SIZE-1:0] IF_pc,
    output logic [WORD_SIZE-1:0] predicted_pc,
    output logic                 btb_hit,
    output logic                 pred_taken,

    input  logic                 resolve_valid,
    input  logic [1:0]           is_J_JR_Branch,
    input  logic [WORD_SIZE-1:0] ID_pc,
    input  logic                 BtbWrite,
    input  logic [WORD_SIZE-1:0] target_address,
    input  logic                 branch_taken
);

    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;
    localparam int ENTRIES  = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_JMP  = 2'd1,
        KIND_JPR  = 2'd2,
        KIND_BR   = 2'd3
    } kind_e;

    // Entry storage.
    logic                 valid_q   [ENTRIES];
    logic [TAG_BITS-1:0]  tag_q     [ENTRIES];
    logic [WORD_SIZE-1:0] target_q  [ENTRIES];
    logic                 is_jump_q [ENTRIES];
    logic [1:0]           ctr_q     [ENTRIES];

    // ------------------------------------------------------------------
    // Lookup (IF side, combinational)
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0]   if_tag;
    logic [WORD_SIZE-1:0]  if_pc_plus1;

    assign if_idx      = IF_pc[INDEX_BITS-1:0];
    assign if_tag      = IF_pc[WORD_SIZE-1:INDEX_BITS];
    // Wraps modulo 2^WORD_SIZE, so 0xFFFF advances to 0x0000.
    assign if_pc_plus1 = IF_pc + {{(WORD_SIZE-1){1'b0}}, 1'b1};

    // The lookup reads the registered array directly. A write in this cycle
    // becomes visible only after the edge, because there is no bypass path.
    assign btb_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken   = btb_hit && (is_jump_q[if_idx] || ctr_q[if_idx][1]);
    assign predicted_pc = pred_taken ? target_q[if_idx] : if_pc_plus1;

    // ------------------------------------------------------------------
    // Resolution (ID side)
    // ------------------------------------------------------------------
    kind_e                 kind;
    logic [INDEX_BITS-1:0] id_idx;
    logic [TAG_BITS-1:0]   id_tag;
    logic                  upd_en;
    logic                  is_br;
    logic                  id_match;
    logic                  alloc;
    logic                  ctr_upd;
    logic                  write_en;
    logic [1:0]            ctr_cur;
    logic [1:0]            ctr_inc;
    logic [1:0]            ctr_dec;
    logic [1:0]            ctr_d;

    assign kind     = kind_e'(is_J_JR_Branch);
    assign id_idx   = ID_pc[INDEX_BITS-1:0];
    assign id_tag   = ID_pc[WORD_SIZE-1:INDEX_BITS];
    assign upd_en   = resolve_valid && (kind != KIND_NONE);
    assign is_br    = (kind == KIND_BR);
    assign id_match = valid_q[id_idx] && (tag_q[id_idx] == id_tag);

    // A not-taken branch never allocates. This keeps the table free of entries
    // that would only redirect fetch to the fall-through path.
    assign alloc    = upd_en && BtbWrite && (!is_br || branch_taken);
    assign ctr_upd  = upd_en && is_br && id_match;
    assign write_en = alloc || ctr_upd;

    assign ctr_cur  = ctr_q[id_idx];
    assign ctr_inc  = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
    assign ctr_dec  = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;

    // NOTE: every path assigns ctr_d, and the first statement is a default.
    // Without that default an incomplete if/else would infer a latch.
    always_comb begin
        ctr_d = ctr_cur;
        if (alloc) begin
            // A hit on a taken branch keeps its training history.
            // A fresh branch starts weakly taken.
            // Jumps are marked strongly taken.
            if (is_br && id_match) ctr_d = ctr_inc;
            else if (is_br)        ctr_d = 2'b10;
            else                   ctr_d = 2'b11;
        end else if (ctr_upd) begin
            ctr_d = branch_taken ? ctr_inc : ctr_dec;
        end
    end

    // NOTE: the whole array is reset here, not just the valid bits. The counters
    // must start at weakly-not-taken, and the outputs must be deterministic
    // during reset. This rules out a RAM macro without reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]   <= 1'b0;
                tag_q[i]     <= '0;
                target_q[i]  <= '0;
                is_jump_q[i] <= 1'b0;
                ctr_q[i]     <= 2'b01;
            end
        end else if (write_en) begin
            // NOTE: non-blocking assignments make every entry update see
            // the pre-edge state. Combinational readers see the same state.
            ctr_q[id_idx] <= ctr_d;
            if (alloc) begin
                valid_q[id_idx]   <= 1'b1;
                tag_q[id_idx]     <= id_tag;
                // JPR/JRL targets come from registers, so they are rewritten
                // every time a misprediction is reported.
                target_q[id_idx]  <= target_address;
                is_jump_q[id_idx] <= !is_br;
            end
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
module tb_btb_predictor;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [15:0] pc;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [15:0] IF_pc;
    logic [15:0] predicted_pc;
    logic        btb_hit;
    logic        pred_taken;
    logic        resolve_valid;
    logic [1:0]  is_J_JR_Branch;
    logic [15:0] ID_pc;
    logic        BtbWrite;
    logic [15:0] target_address;
    logic        branch_taken;

    int    compared   = 0;
    int    mismatched = 0;
    exp_t  exp_q[$];
    string name_q[$];

    btb_predictor #(.WORD_SIZE(16), .INDEX_BITS(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .IF_pc          (IF_pc),
        .predicted_pc   (predicted_pc),
        .btb_hit        (btb_hit),
        .pred_taken     (pred_taken),
        .resolve_valid  (resolve_valid),
        .is_J_JR_Branch (is_J_JR_Branch),
        .ID_pc          (ID_pc),
        .BtbWrite       (BtbWrite),
        .target_address (target_address),
        .branch_taken   (branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Pop the oldest expectation and compare it with the DUT's current outputs.
    task automatic compare_front();
        exp_t  e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        compared++;
        assert (btb_hit === e.hit) else begin
            mismatched++;
            $error("FAIL %s.hit: observed %b expected %b", n, btb_hit, e.hit);
        end
        compared++;
        assert (pred_taken === e.taken) else begin
            mismatched++;
            $error("FAIL %s.taken: observed %b expected %b", n, pred_taken, e.taken);
        end
        compared++;
        assert (predicted_pc === e.pc) else begin
            mismatched++;
            $error("FAIL %s.pc: observed %h expected %h", n, predicted_pc, e.pc);
        end
    endtask

    // Drive a fetch PC, push the expected prediction, and check it after it settles.
    task automatic lookup(input logic [15:0] pc, input logic h, input logic t,
                          input logic [15:0] npc, input string n);
        exp_t e;
        IF_pc   = pc;
        e.hit   = h;
        e.taken = t;
        e.pc    = npc;
        exp_q.push_back(e);
        name_q.push_back(n);
        #1;
        compare_front();
    endtask

    task automatic miss(input logic [15:0] pc, input string n);
        lookup(pc, 1'b0, 1'b0, pc + 16'd1, n);
    endtask

    task automatic drive(input logic rv, input logic [1:0] kind, input logic [15:0] id,
                         input logic [15:0] tgt, input logic bw, input logic tk);
        resolve_valid  = rv;
        is_J_JR_Branch = kind;
        ID_pc          = id;
        target_address = tgt;
        BtbWrite       = bw;
        branch_taken   = tk;
    endtask

    // Advance one edge and leave inputs idle; return 1ns after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic [1:0] kind, input logic [15:0] id,
                           input logic [15:0] tgt, input logic bw, input logic tk);
        drive(1'b1, kind, id, tgt, bw, tk);
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        IF_pc   = 16'h0000;
        drive(1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        #2;
        miss(16'h0010, "in_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Post-reset lookups, including PC wrap-around.
        miss(16'h0010, "rst_0010");
        miss(16'hFFFF, "rst_wrap");

        // JMP allocation; the same-cycle lookup must still see the old contents.
        drive(1'b1, 2'd1, 16'h0020, 16'h0040, 1'b1, 1'b0);
        miss(16'h0020, "jmp_same_cycle");
        tick();
        lookup(16'h0020, 1, 1, 16'h0040, "jmp_next");

        // Counter walk on the conditional branch at 0x0030.
        resolve(2'd3, 16'h0030, 16'h0005, 1'b1, 1'b1);           // ctr 10
        lookup(16'h0030, 1, 1, 16'h0005, "br_alloc");
        resolve(2'd3, 16'h0030, 16'h0031, 1'b1, 1'b0);           // ctr 01
        lookup(16'h0030, 1, 0, 16'h0031, "br_nt1");
        resolve(2'd3, 16'h0030, 16'h0031, 1'b0, 1'b0);           // ctr 00
        lookup(16'h0030, 1, 0, 16'h0031, "br_nt2");
        resolve(2'd3, 16'h0030, 16'h0005, 1'b0, 1'b1);           // ctr 01
        lookup(16'h0030, 1, 0, 16'h0031, "br_t_nowrite");
        resolve(2'd3, 16'h0030, 16'h0005, 1'b1, 1'b1);           // ctr 10
        lookup(16'h0030, 1, 1, 16'h0005, "br_t2");
        for (int i = 0; i < 3; i++) resolve(2'd3, 16'h0030, 16'h0005, 1'b0, 1'b1);
        lookup(16'h0030, 1, 1, 16'h0005, "br_sat_hi");
        resolve(2'd3, 16'h0030, 16'h0005, 1'b0, 1'b0);           // 11 -> 10
        lookup(16'h0030, 1, 1, 16'h0005, "br_sat_nt1");
        resolve(2'd3, 16'h0030, 16'h0031, 1'b1, 1'b0);           // 10 -> 01
        lookup(16'h0030, 1, 0, 16'h0031, "br_sat_nt2");

        // Aliasing at index 0x20.
        miss(16'h0120, "alias_miss");
        resolve(2'd1, 16'h0120, 16'h0300, 1'b1, 1'b0);
        lookup(16'h0120, 1, 1, 16'h0300, "alias_hit");
        miss(16'h0020, "alias_evicted");

        // Register-target jump is overwritten on every BtbWrite.
        resolve(2'd2, 16'h0050, 16'h0100, 1'b1, 1'b0);
        lookup(16'h0050, 1, 1, 16'h0100, "jpr_first");
        resolve(2'd2, 16'h0050, 16'h0200, 1'b1, 1'b0);
        lookup(16'h0050, 1, 1, 16'h0200, "jpr_rewrite");

        // A not-taken branch that misses must not allocate.
        resolve(2'd3, 16'h0060, 16'h0070, 1'b1, 1'b0);
        miss(16'h0060, "nt_no_alloc");

        // Unqualified updates: resolve_valid=0, kind=0, and a glitch between edges.
        drive(1'b0, 2'd1, 16'h0120, 16'h0777, 1'b1, 1'b0);
        tick();
        drive(1'b1, 2'd0, 16'h0050, 16'h0777, 1'b1, 1'b1);
        tick();
        #1;
        drive(1'b1, 2'd1, 16'h0060, 16'h0888, 1'b1, 1'b0);
        #2;
        drive(1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        lookup(16'h0120, 1, 1, 16'h0300, "q_0120");
        lookup(16'h0050, 1, 1, 16'h0200, "q_0050");
        lookup(16'h0030, 1, 0, 16'h0031, "q_0030");
        miss(16'h0020, "q_0020");
        miss(16'h0060, "q_0060");

        // Asynchronous reset between clock edges.
        lookup(16'h0120, 1, 1, 16'h0300, "pre_async");
        reset_n = 1'b0;
        miss(16'h0120, "async_immediate");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        miss(16'h0120, "post_rst_0120");
        miss(16'h0050, "post_rst_0050");
        miss(16'h0030, "post_rst_0030");
        miss(16'h0020, "post_rst_0020");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
Branch target buffer and direction predictor for the pipelined TSC CPU. It receives branch resolutions from ID-stage hazard detection: BtbWrite, the correct target, the taken flag and the instruction kind. It serves a same-cycle next-PC prediction to the IF stage. The block is direct-mapped, tagged, and has a 2-bit saturating counter per entry for conditional branches.

Parameters:
WORD_SIZE, 16, PC/target width
INDEX_BITS, 8, log2 of entry count (256 entries); tag width = WORD_SIZE-INDEX_BITS

Ports:
clk  input  1  clock; all state updates on posedge
reset_n  input  1  asynchronous active-low reset
IF_pc  input  16  PC currently being fetched
predicted_pc  output  16  next PC for the IF stage
btb_hit  output  1  valid entry with matching tag for IF_pc
pred_taken  output  1  prediction redirects to the stored target
resolve_valid  input  1  ID instruction resolves this cycle (low when stalled or flushed)
is_J_JR_Branch  input  2  ID kind: 0 none, 1 JMP/JAL, 2 JPR/JRL, 3 conditional branch
ID_pc  input  16  PC of the resolving instruction
BtbWrite  input  1  IF-stage guess for ID instruction was wrong; target write request
target_address  input  16  resolved target of the ID instruction
branch_taken  input  1  conditional branch outcome (ignored unless kind==3)

Behaviour:
- Entry i holds: valid, tag[WORD_SIZE-INDEX_BITS-1:0], target[15:0], is_jump, ctr[1:0].
- index = pc[INDEX_BITS-1:0]; tag = pc[15:INDEX_BITS].
- Reset (async, while reset_n low): all valid=0, ctr=2'b01, target=0, tag=0, is_jump=0.
  - Outputs are combinational, so during reset btb_hit=0, pred_taken=0 and predicted_pc=IF_pc+1.
  - A reset between edges takes effect immediately.
- Lookup (combinational, zero latency):
  - btb_hit = valid[idx] && tag[idx]==IF_pc tag.
  - pred_taken = btb_hit && (is_jump[idx] || ctr[idx][1]).
  - predicted_pc = pred_taken ? target[idx] : IF_pc+1, computed modulo 2^16 (0xFFFF -> 0x0000).
- Update occurs at posedge only when resolve_valid=1 and is_J_JR_Branch!=0; no state change otherwise. Let m = valid && tag match for ID_pc.
- Counter update: applies when kind==3 and m=1.
  - Taken: ctr saturating increment (max 2'b11).
  - Not taken: ctr saturating decrement (min 2'b00).
- Allocation/overwrite happens when BtbWrite=1 and (kind!=3 or branch_taken=1). It writes:
  - valid=1, tag from ID_pc, target=target_address.
  - is_jump=(kind!=3).
  - ctr: if kind==3 and m=1, the saturating increment result; otherwise 2'b10 for kind 3 and 2'b11 for kind 1/2.
  - A differing tag at the same index is evicted (direct-mapped, no replacement choice).
- No allocation happens on a miss for a not-taken branch. BtbWrite=1 with kind==3 and branch_taken=0 leaves target/tag unchanged; a counter update still applies if m=1.
- JPR/JRL targets are overwritten every time BtbWrite fires, because register targets can change.
- Same-cycle lookup of an index being written returns the pre-edge contents; there is no bypass. The new entry is visible the cycle after the edge.
- Stall/flush qualification is the caller's job via resolve_valid. Repeated assertion on a held ID instruction would double-count, so resolve_valid must be asserted once per instruction.
- BtbWrite and resolve_valid must be sampled only at posedge; glitches between edges are ignored.

Test Plan:
- Reset, then IF_pc=0x0010 -> btb_hit=0, pred_taken=0, predicted_pc=0x0011. IF_pc=0xFFFF -> predicted_pc=0x0000.
- Resolve JMP: ID_pc=0x0020, kind=1, target 0x0040, BtbWrite=1, resolve_valid=1 -> next cycle IF_pc=0x0020 gives hit=1, pred_taken=1, predicted_pc=0x0040. With IF_pc=0x0020 during the write cycle itself -> hit=0, predicted_pc=0x0021.
- Counter walk on branch ID_pc=0x0030, target 0x0005:
  - Taken+BtbWrite -> ctr=10, predicts 0x0005.
  - Two not-taken resolves -> ctr=00, predicts 0x0031.
  - One taken without BtbWrite -> ctr=01, still 0x0031.
  - Second taken -> ctr=10, predicts 0x0005.
  - Three more taken -> stays 11.
- Aliasing:
  - With 0x0020 cached, IF_pc=0x0120 -> miss, predicted 0x0121.
  - Allocate JMP at 0x0120 -> 0x0300; then IF_pc=0x0120 hits 0x0300 and IF_pc=0x0020 misses (0x0021).
- Qualification: not-taken branch miss with BtbWrite=1 -> no entry created. Any update with resolve_valid=0 -> array unchanged, checked by re-reading all prior entries.
- Async reset mid-run: drive reset_n low between edges after populating entries -> btb_hit falls immediately. After release every previous PC misses and predicts PC+1.
